// File: rtl/console_usb_seq.sv
// console_usb_seq: command / read sequencer for a multi-lane USB console link.
// Define CONSOLE_USB_RETRY_EN to build the resend-on-timeout path (CMD_RETRY + retry counter).
module console_usb_seq #(
    parameter int unsigned LANE_NUM     = 8,
    parameter int unsigned LINK_NUM     = 7_500_000,
    parameter int unsigned SEND_TMO     = 1_000_000,
    parameter int unsigned RETRY_MAX    = 2,
    parameter int unsigned DATA_IDX_NUM = 6,
    parameter logic [31:0] DEVICE_IDX   = 32'h13579BDF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fs_conf,
    output logic                fd_conf,
    input  logic                fs_conv,
    output logic                fd_conv,
    output logic                fs_send,
    input  logic [LANE_NUM-1:0] fd_send,
    input  logic [LANE_NUM-1:0] fs_read,
    output logic                fd_read,
    input  logic [LANE_NUM-1:0] lane_mask,
    output logic [3:0]          send_btype,
    output logic [3:0]          read_btype,
    input  logic [3:0]          core_data_idx,
    output logic [3:0]          data_idx,
    output logic [31:0]         device_idx,
    output logic                err,
    output logic [LANE_NUM-1:0] err_lane
);

    typedef enum logic [2:0] {
        MAIN_IDLE,
        MAIN_WAIT,
        CMD_PREP,
        CMD_SEND,
`ifdef CONSOLE_USB_RETRY_EN
        CMD_RETRY,
`endif
        CMD_DONE,
        READ_WORK,
        READ_DONE
    } state_t;

    typedef enum logic [1:0] {KIND_CONF, KIND_CONV, KIND_LINK} kind_t;

    localparam logic [31:0] LINK_LAST = 32'(LINK_NUM - 1);
    localparam logic [31:0] TMO_LAST  = 32'(SEND_TMO - 1);
    localparam logic [4:0]  DIDX_MOD  = 5'(DATA_IDX_NUM);

    state_t      state, state_nxt;
    kind_t       kind, kind_nxt;
    logic [31:0] idle_cnt;
    logic [31:0] tmo_cnt;
    logic        send_ok;
    logic        read_all;
    logic        read_none;
    logic        fail;
    logic [4:0]  idx_sum;

`ifdef CONSOLE_USB_RETRY_EN
    localparam logic [7:0] RETRY_LIM = 8'(RETRY_MAX);
    logic [7:0] retry_cnt;
`endif

    // Disabled lanes are forced to "done"/"ready" so they never block a reduction.
    assign send_ok   = &(fd_send | ~lane_mask);
    assign read_all  = (lane_mask != '0) && (&(fs_read | ~lane_mask));
    assign read_none = ((fs_read & lane_mask) == '0);
    assign idx_sum   = 5'd2 + {1'b0, core_data_idx};

    assign fs_send    = (state == CMD_SEND);
    assign fd_conf    = (state == CMD_DONE) && (kind == KIND_CONF);
    assign fd_conv    = (state == CMD_DONE) && (kind == KIND_CONV);
    assign fd_read    = (state == READ_DONE);
    assign device_idx = DEVICE_IDX;

    always_comb begin
        state_nxt = state;
        kind_nxt  = kind;
        fail      = 1'b0;
        case (state)
            MAIN_IDLE: state_nxt = MAIN_WAIT;
            MAIN_WAIT: begin
                if (fs_conf) begin
                    state_nxt = CMD_PREP;
                    kind_nxt  = KIND_CONF;
                end else if (fs_conv) begin
                    state_nxt = CMD_PREP;
                    kind_nxt  = KIND_CONV;
                end else if (read_all) begin
                    state_nxt = READ_WORK;
                end else if (idle_cnt == LINK_LAST) begin
                    state_nxt = CMD_PREP;
                    kind_nxt  = KIND_LINK;
                end
            end
            CMD_PREP: state_nxt = CMD_SEND;
            CMD_SEND: begin
                if (send_ok) begin
                    state_nxt = CMD_DONE;
                end else if (tmo_cnt == TMO_LAST) begin
`ifdef CONSOLE_USB_RETRY_EN
                    if (retry_cnt < RETRY_LIM) begin
                        state_nxt = CMD_RETRY;
                    end else begin
                        fail      = 1'b1;
                        state_nxt = CMD_DONE;
                    end
`else
                    fail      = 1'b1;
                    state_nxt = CMD_DONE;
`endif
                end
            end
`ifdef CONSOLE_USB_RETRY_EN
            CMD_RETRY: state_nxt = CMD_SEND;
`endif
            CMD_DONE: begin
                case (kind)
                    KIND_CONF: if (!fs_conf) state_nxt = MAIN_WAIT;
                    KIND_CONV: if (!fs_conv) state_nxt = MAIN_WAIT;
                    default:   state_nxt = MAIN_WAIT;
                endcase
            end
            READ_WORK: state_nxt = READ_DONE;
            READ_DONE: if (read_none) state_nxt = MAIN_WAIT;
            default:   state_nxt = MAIN_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= MAIN_IDLE;
            kind       <= KIND_CONF;
            idle_cnt   <= '0;
            tmo_cnt    <= '0;
            send_btype <= '0;
            read_btype <= '0;
            data_idx   <= '0;
            err        <= 1'b0;
            err_lane   <= '0;
`ifdef CONSOLE_USB_RETRY_EN
            retry_cnt  <= '0;
`endif
        end else begin
            state    <= state_nxt;
            kind     <= kind_nxt;
            idle_cnt <= (state == MAIN_WAIT) ? idle_cnt + 32'd1 : '0;
            // Leaving CMD_SEND (done, retry or fail) rearms the timeout for the next burst.
            tmo_cnt  <= (state == CMD_SEND) ? tmo_cnt + 32'd1 : '0;
            if (state == MAIN_IDLE) read_btype <= 4'b1001;
            if (state == CMD_PREP) begin
                err      <= 1'b0;
                err_lane <= '0;
`ifdef CONSOLE_USB_RETRY_EN
                retry_cnt <= '0;
`endif
                case (kind)
                    KIND_CONF: begin
                        send_btype <= 4'b0001;
                        read_btype <= 4'b1010;
                    end
                    KIND_CONV: begin
                        send_btype <= 4'b1001;
                        read_btype <= 4'b0101;
                        data_idx   <= 4'((idx_sum >= DIDX_MOD) ? idx_sum - DIDX_MOD : idx_sum);
                    end
                    default: send_btype <= 4'b1011;
                endcase
            end
            if (fail) begin
                err      <= 1'b1;
                err_lane <= lane_mask & ~fd_send;
            end
`ifdef CONSOLE_USB_RETRY_EN
            if (state == CMD_RETRY) retry_cnt <= retry_cnt + 8'd1;
`endif
        end
    end

endmodule

// File: tb/tb_console_usb_seq.sv
// Self-checking bench for console_usb_seq: vector table, directed corner sequences,
// and randomized transactions against a transaction-level reference model.
module tb_console_usb_seq;

    localparam int LINK_N = 100;
    localparam int TMO    = 16;
    localparam int RMAX   = 2;
`ifdef CONSOLE_USB_RETRY_EN
    localparam int NB_FAIL = RMAX + 1;
`else
    localparam int NB_FAIL = 1;
`endif
    localparam logic [31:0] DEV = 32'h13579BDF;

    logic        clk = 1'b0;
    logic        rst;
    logic        fs_conf, fd_conf, fs_conv, fd_conv, fs_send, fd_read, err;
    logic [7:0]  fd_send, fs_read, lane_mask, err_lane;
    logic [3:0]  send_btype, read_btype, core_data_idx, data_idx;
    logic [31:0] device_idx;

    console_usb_seq #(
        .LANE_NUM(8), .LINK_NUM(LINK_N), .SEND_TMO(TMO), .RETRY_MAX(RMAX),
        .DATA_IDX_NUM(6), .DEVICE_IDX(DEV)
    ) dut (
        .clk(clk), .rst(rst),
        .fs_conf(fs_conf), .fd_conf(fd_conf),
        .fs_conv(fs_conv), .fd_conv(fd_conv),
        .fs_send(fs_send), .fd_send(fd_send),
        .fs_read(fs_read), .fd_read(fd_read),
        .lane_mask(lane_mask),
        .send_btype(send_btype), .read_btype(read_btype),
        .core_data_idx(core_data_idx), .data_idx(data_idx),
        .device_idx(device_idx),
        .err(err), .err_lane(err_lane)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind; logic [7:0] mask; logic [7:0] dead; logic [3:0] core; int dly;
        logic [3:0] sb; logic [3:0] rb; logic [3:0] di; logic er; logic [7:0] el; int len;
    } vec_t;

    typedef struct {
        logic [3:0] sb; logic [3:0] rb; logic [3:0] di; logic er; logic [7:0] el;
        int nb; int len0; int lenlast; int gmin; int gmax; int lat;
        bit tmo; bit fd_ok; bit dropped;
    } obs_t;

    int checks = 0;
    int failures = 0;

    logic [3:0] m_rb, m_di;
    logic       m_err;
    logic [7:0] m_el;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Expected outcome of one conf/conv command, from the behavioural rules.
    task automatic model(input int kind, input logic [7:0] mask, input logic [7:0] dead,
                         input logic [3:0] core, input int dly, output vec_t v);
        int s;
        v.kind = kind; v.mask = mask; v.dead = dead; v.core = core; v.dly = dly;
        v.sb = (kind == 0) ? 4'h1 : 4'h9;
        m_rb = (kind == 0) ? 4'hA : 4'h5;
        if (kind == 1) begin
            s = 2 + int'(core);
            m_di = 4'((s >= 6) ? s - 6 : s);
        end
        m_el  = mask & dead;
        m_err = (m_el != 8'h00);
        v.rb = m_rb; v.di = m_di; v.er = m_err; v.el = m_el;
        v.len = (mask == 8'h00 || dly < 1) ? 1 : dly;
    endtask

    task automatic run_cmd(input int kind, input logic [7:0] mask, input logic [7:0] dead,
                           input logic [3:0] core, input int dly, output obs_t o);
        int cyc, nsend, gap;
        logic prev;
        o = '{default: 0};
        nsend = 0; gap = 0; prev = 1'b0; cyc = 0;
        lane_mask = mask; core_data_idx = core; fd_send = '0;
        if (kind == 0) fs_conf = 1'b1; else fs_conv = 1'b1;
        while (1'b1) begin
            @(negedge clk);
            cyc++;
            if (fs_send && !prev) begin
                o.nb++;
                if (o.nb == 1) o.lat = cyc;
                else begin
                    if (o.nb == 2 || gap < o.gmin) o.gmin = gap;
                    if (gap > o.gmax) o.gmax = gap;
                end
                nsend = 0;
            end
            if (fs_send) nsend++;
            if (!fs_send && prev) begin
                if (o.nb == 1) o.len0 = nsend;
                o.lenlast = nsend;
                gap = 1;
            end else if (!fs_send && o.nb > 0) begin
                gap++;
            end
            prev = fs_send;
            if (fd_conf || fd_conv) break;
            if (cyc >= 400) begin
                o.tmo = 1'b1;
                break;
            end
            fd_send = (fs_send && nsend >= dly) ? ~dead : '0;
        end
        o.sb = send_btype; o.rb = read_btype; o.di = data_idx; o.er = err; o.el = err_lane;
        o.fd_ok = (kind == 0) ? (fd_conf && !fd_conv) : (fd_conv && !fd_conf);
        fs_conf = 1'b0; fs_conv = 1'b0; fd_send = '0;
        @(negedge clk);
        o.dropped = !fd_conf && !fd_conv;
    endtask

    task automatic check_cmd(input string tag, input vec_t v, input obs_t o);
        chk({tag, ".no_hang"}, 32'(o.tmo), 0);
        chk({tag, ".send_latency"}, o.lat, 2);
        chk({tag, ".bursts"}, o.nb, v.er ? NB_FAIL : 1);
        chk({tag, ".burst_len"}, o.len0, v.er ? TMO : v.len);
        if (o.nb > 1) begin
            chk({tag, ".last_burst_len"}, o.lenlast, TMO);
            chk({tag, ".gap_min"}, o.gmin, 1);
            chk({tag, ".gap_max"}, o.gmax, 1);
        end
        chk({tag, ".fd_kind"}, 32'(o.fd_ok), 1);
        chk({tag, ".fd_drop"}, 32'(o.dropped), 1);
        chk({tag, ".send_btype"}, 32'(o.sb), 32'(v.sb));
        chk({tag, ".read_btype"}, 32'(o.rb), 32'(v.rb));
        chk({tag, ".data_idx"}, 32'(o.di), 32'(v.di));
        chk({tag, ".err"}, 32'(o.er), 32'(v.er));
        chk({tag, ".err_lane"}, 32'(o.el), 32'(v.el));
    endtask

    task automatic run_read(input string tag, input logic [7:0] mask, input logic [7:0] junk,
                            input int hold);
        int lat, bad;
        lane_mask = mask;
        fs_read = (mask & (mask - 8'd1)) | (junk & ~mask);
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (fd_read || fs_send) bad++;
        end
        chk({tag, ".partial_ready_ignored"}, bad, 0);
        fs_read = mask | (junk & ~mask);
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (fd_read) begin
                lat = c;
                break;
            end
        end
        chk({tag, ".read_latency"}, lat, 2);
        bad = 0;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (!fd_read || fs_send) bad++;
        end
        chk({tag, ".fd_read_hold"}, bad, 0);
        chk({tag, ".read_btype"}, 32'(read_btype), 32'(m_rb));
        chk({tag, ".err_kept"}, 32'(err), 32'(m_err));
        chk({tag, ".err_lane_kept"}, 32'(err_lane), 32'(m_el));
        fs_read = junk & ~mask;
        @(negedge clk);
        chk({tag, ".fd_read_drop"}, 32'(fd_read), 0);
        fs_read = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl[8];
        vec_t v;
        obs_t o;
        int   found, first;

        rst = 1'b1; fs_conf = 1'b0; fs_conv = 1'b0; fd_send = '0; fs_read = '0;
        lane_mask = '0; core_data_idx = '0;

        // kind, mask, dead, core, dly | send_btype, read_btype, data_idx, err, err_lane, burst_len
        tbl[0] = '{0, 8'hFF, 8'h00, 4'd0,  3, 4'h1, 4'hA, 4'h0, 1'b0, 8'h00, 3};
        tbl[1] = '{1, 8'hFF, 8'h00, 4'd5,  1, 4'h9, 4'h5, 4'h1, 1'b0, 8'h00, 1};
        tbl[2] = '{1, 8'hFF, 8'h00, 4'd15, 2, 4'h9, 4'h5, 4'hB, 1'b0, 8'h00, 2};
        tbl[3] = '{0, 8'hFF, 8'h08, 4'd0,  1, 4'h1, 4'hA, 4'hB, 1'b1, 8'h08, 16};
        tbl[4] = '{1, 8'h00, 8'hFF, 4'd3,  5, 4'h9, 4'h5, 4'h5, 1'b0, 8'h00, 1};
        tbl[5] = '{0, 8'h0F, 8'hF0, 4'd0,  2, 4'h1, 4'hA, 4'h5, 1'b0, 8'h00, 2};
        tbl[6] = '{1, 8'h81, 8'h80, 4'd4,  1, 4'h9, 4'h5, 4'h0, 1'b1, 8'h80, 16};
        tbl[7] = '{1, 8'hFF, 8'h00, 4'd3,  0, 4'h9, 4'h5, 4'h5, 1'b0, 8'h00, 1};

        repeat (3) @(negedge clk);
        chk("reset.fs_send", 32'(fs_send), 0);
        chk("reset.fd_conf", 32'(fd_conf), 0);
        chk("reset.fd_conv", 32'(fd_conv), 0);
        chk("reset.fd_read", 32'(fd_read), 0);
        chk("reset.err", 32'(err), 0);
        chk("reset.err_lane", 32'(err_lane), 0);
        chk("reset.send_btype", 32'(send_btype), 0);
        chk("reset.read_btype", 32'(read_btype), 0);
        chk("reset.data_idx", 32'(data_idx), 0);
        chk("reset.device_idx", device_idx, DEV);
        rst = 1'b0;
        @(negedge clk);
        chk("idle.read_btype_load", 32'(read_btype), 32'h9);

        for (int i = 0; i < 8; i++) begin
            run_cmd(tbl[i].kind, tbl[i].mask, tbl[i].dead, tbl[i].core, tbl[i].dly, o);
            check_cmd($sformatf("vec%0d", i), tbl[i], o);
        end

        // conf and conv raised together: conf wins, conv follows once conf is released.
        lane_mask = 8'hFF; fd_send = 8'hFF; core_data_idx = 4'd9;
        fs_conf = 1'b1; fs_conv = 1'b1;
        found = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (fd_conf || fd_conv) begin
                found = 1;
                break;
            end
        end
        chk("prio.first_done_seen", found, 1);
        chk("prio.fd_conf_first", 32'(fd_conf), 1);
        chk("prio.fd_conv_not_first", 32'(fd_conv), 0);
        chk("prio.conf_send_btype", 32'(send_btype), 32'h1);
        fs_conf = 1'b0;
        found = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (fd_conv) begin
                found = 1;
                break;
            end
        end
        chk("prio.conv_served", found, 1);
        chk("prio.conv_send_btype", 32'(send_btype), 32'h9);
        chk("prio.conv_data_idx", 32'(data_idx), 32'h5);
        fs_conv = 1'b0; fd_send = '0;
        @(negedge clk);

        // Reset asserted in the middle of a send burst.
        fs_conf = 1'b1;
        found = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (fs_send) begin
                found = 1;
                break;
            end
        end
        chk("rst_mid.send_started", found, 1);
        repeat (5) @(negedge clk);
        rst = 1'b1; fs_conf = 1'b0;
        @(negedge clk);
        chk("rst_mid.fs_send", 32'(fs_send), 0);
        chk("rst_mid.fd_conf", 32'(fd_conf), 0);
        chk("rst_mid.send_btype", 32'(send_btype), 0);
        chk("rst_mid.read_btype", 32'(read_btype), 0);
        chk("rst_mid.data_idx", 32'(data_idx), 0);
        chk("rst_mid.err_err_lane", {23'd0, err, err_lane}, 0);
        chk("rst_mid.device_idx", device_idx, DEV);

        // Keep-alive link after LINK_N idle cycles with no requests.
        @(negedge clk);
        rst = 1'b0; lane_mask = 8'hFF; fd_send = 8'hFF;
        first = -1;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            if (fs_send) begin
                first = c;
                break;
            end
        end
        chk("link.latency", first, LINK_N + 2);
        @(negedge clk);
        chk("link.burst_len", 32'(fs_send), 0);
        chk("link.send_btype", 32'(send_btype), 32'hB);
        chk("link.read_btype_kept", 32'(read_btype), 32'h9);
        chk("link.no_fd", {30'd0, fd_conf, fd_conv}, 0);
        fd_send = '0;
        @(negedge clk);
        m_rb = 4'h9; m_di = 4'h0; m_err = 1'b0; m_el = 8'h00;

        for (int i = 0; i < 40; i++) begin
            int op, r, dly;
            logic [7:0] mask, dead;
            logic [3:0] core;
            op = $urandom_range(0, 2);
            if (op == 2) begin
                mask = 8'($urandom_range(1, 255));
                run_read($sformatf("rnd%0d.read", i), mask, 8'($urandom), $urandom_range(0, 4));
            end else begin
                mask = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
                r = $urandom_range(0, 3);
                dead = (r < 2) ? 8'h00 : (r == 2) ? (8'h01 << $urandom_range(0, 7)) : 8'($urandom);
                core = 4'($urandom_range(0, 15));
                dly  = $urandom_range(0, 10);
                model(op, mask, dead, core, dly, v);
                run_cmd(op, mask, dead, core, dly, o);
                check_cmd($sformatf("rnd%0d.cmd", i), v, o);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
